// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence feeder and its result FIFO.
package geofence_pkg;
    localparam int PT_W          = 10;
    localparam int PTS_PER_FRAME = 7;
    localparam int ENGINE_LAT    = 13;
    localparam int ID_W          = 8;

    typedef struct packed {
        logic [PT_W-1:0] x;
        logic [PT_W-1:0] y;
    } point_t;

    typedef enum logic {
        SEND = 1'b0,
        WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/geofence_res_fifo.sv
// Small circular result FIFO; the producer guarantees it never pushes when full.
module geofence_res_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/geofence_feeder.sv
// Ping-pong frame buffer feeding the geofence engine's fixed 7-cycle read window.
// Optional GEOF_FRAME_ID_EN adds a per-frame 8-bit id carried through to the result.
module geofence_feeder
    import geofence_pkg::*;
#(
    parameter int TIMEOUT   = 32,
    parameter int RES_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PT_W-1:0] in_x,
    input  logic [PT_W-1:0] in_y,
`ifdef GEOF_FRAME_ID_EN
    input  logic [ID_W-1:0] in_id,
    output logic [ID_W-1:0] res_id,
`endif
    output logic [PT_W-1:0] geo_x,
    output logic [PT_W-1:0] geo_y,
    input  logic            geo_valid,
    input  logic            geo_is_inside,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_inside,
    output logic            res_timeout,
    output logic            err_proto,
    output logic            err_timeout
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
`ifdef GEOF_FRAME_ID_EN
    localparam int RES_W = ID_W + 2;
`else
    localparam int RES_W = 2;
`endif
    localparam logic [2:0]        LAST_PT   = 3'(PTS_PER_FRAME - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    point_t            bank [2][PTS_PER_FRAME];
    logic [1:0]        bank_full;
    logic              fill_ptr;
    logic              send_ptr;
    logic [2:0]        ld_cnt;
    logic [2:0]        pt_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    state_t            state;
    logic              frame_real;

    logic              load_beat;
    logic              slot_start;
    logic              credit_ok;
    logic              send_real;
    logic              wait_done;
    logic              push;
    logic              pop;
    logic [1:0]        res_bits;
    logic [RES_W-1:0]  push_data;
    logic [RES_W-1:0]  head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign in_ready   = ~bank_full[fill_ptr];
    assign load_beat  = in_valid & in_ready;
    assign slot_start = (state == SEND) && (pt_cnt == '0);
    // A new slot only starts after the previous frame has pushed, so nothing is in flight here.
    assign credit_ok  = int'(fifo_count) < RES_DEPTH;
    assign send_real  = slot_start ? (bank_full[send_ptr] & credit_ok) : frame_real;
    assign wait_done  = (state == WAIT) && (geo_valid || (wait_cnt == LAST_WAIT));
    assign push       = wait_done & frame_real;
    assign res_bits   = geo_valid ? {geo_is_inside, 1'b0} : 2'b01;
    assign pop        = res_valid & res_ready;

    always_comb begin
        geo_x = '0;
        geo_y = '0;
        if ((state == SEND) && send_real) begin
            geo_x = bank[send_ptr][pt_cnt].x;
            geo_y = bank[send_ptr][pt_cnt].y;
        end
    end

    always_ff @(posedge clk) begin
        if (load_beat) begin
            bank[fill_ptr][ld_cnt] <= '{x: in_x, y: in_y};
        end
    end

`ifdef GEOF_FRAME_ID_EN
    logic [ID_W-1:0] bank_id [2];
    logic [ID_W-1:0] cur_id;

    always_ff @(posedge clk) begin
        if (load_beat && (ld_cnt == '0)) begin
            bank_id[fill_ptr] <= in_id;
        end
        if (slot_start) begin
            cur_id <= bank_id[send_ptr];
        end
    end

    assign push_data = {cur_id, res_bits};
    assign res_id    = res_valid ? head[RES_W-1:2] : '0;
`else
    assign push_data = res_bits;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_full   <= '0;
            fill_ptr    <= 1'b0;
            send_ptr    <= 1'b0;
            ld_cnt      <= '0;
            state       <= SEND;
            pt_cnt      <= '0;
            wait_cnt    <= '0;
            frame_real  <= 1'b0;
            err_proto   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (load_beat) begin
                if (ld_cnt == LAST_PT) begin
                    bank_full[fill_ptr] <= 1'b1;
                    fill_ptr            <= ~fill_ptr;
                    ld_cnt              <= '0;
                end else begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
            end
            case (state)
                SEND: begin
                    if (geo_valid) begin
                        err_proto <= 1'b1;
                    end
                    if (slot_start) begin
                        frame_real <= send_real;
                    end
                    if (pt_cnt == LAST_PT) begin
                        state    <= WAIT;
                        pt_cnt   <= '0;
                        wait_cnt <= '0;
                        if (send_real) begin
                            bank_full[send_ptr] <= 1'b0;
                            send_ptr            <= ~send_ptr;
                        end
                    end else begin
                        pt_cnt <= pt_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_done) begin
                        state <= SEND;
                        if (!geo_valid) begin
                            err_timeout <= 1'b1;
                        end
                    end
                end
                default: state <= SEND;
            endcase
        end
    end

    geofence_res_fifo #(
        .DEPTH (RES_DEPTH),
        .WIDTH (RES_W)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_valid   = ~fifo_empty;
    assign res_inside  = res_valid & head[1];
    assign res_timeout = res_valid & head[0];
endmodule

// File: tb/tb_geofence_feeder.sv
// Scoreboard bench for geofence_feeder with a simple bounding-box engine model.
module tb_geofence_feeder;
    import geofence_pkg::*;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_x = '0;
    logic [9:0] in_y = '0;
    logic [9:0] geo_x;
    logic [9:0] geo_y;
    logic       geo_valid = 1'b0;
    logic       geo_is_inside = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic       res_inside;
    logic       res_timeout;
    logic       err_proto;
    logic       err_timeout;
`ifdef GEOF_FRAME_ID_EN
    logic [7:0] in_id = '0;
    logic [7:0] res_id;
`endif

    geofence_feeder #(.TIMEOUT(TIMEOUT), .RES_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
`ifdef GEOF_FRAME_ID_EN
        .in_id         (in_id),
        .res_id        (res_id),
`endif
        .geo_x         (geo_x),
        .geo_y         (geo_y),
        .geo_valid     (geo_valid),
        .geo_is_inside (geo_is_inside),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_inside    (res_inside),
        .res_timeout   (res_timeout),
        .err_proto     (err_proto),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [139:0] exp_frame_q [$];
    logic [1:0]   exp_res_q [$];

    bit suppress  = 1'b0;
    bit proto_arm = 1'b0;
    int phase     = 0;
    bit eng_real  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_vec(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Point 0 is the object; vertices form an s-by-s square with two midpoints.
    function automatic logic [139:0] make_frame(input int ox, input int oy, input int s);
        int xs[7];
        int ys[7];
        logic [139:0] f;
        xs = '{ox, 0, s, s, 0, 0, s / 2};
        ys = '{oy, 0, 0, s, s, s / 2, 0};
        f = '0;
        for (int i = 0; i < 7; i++) f[i*20 +: 20] = {10'(xs[i]), 10'(ys[i])};
        return f;
    endfunction

    function automatic logic bbox_inside(input logic [139:0] f);
        int ox, oy, mnx, mxx, mny, mxy, vx, vy;
        ox = int'(f[10 +: 10]);
        oy = int'(f[0 +: 10]);
        mnx = 1023; mny = 1023; mxx = 0; mxy = 0;
        for (int i = 1; i < 7; i++) begin
            vx = int'(f[i*20+10 +: 10]);
            vy = int'(f[i*20 +: 10]);
            if (vx < mnx) mnx = vx;
            if (vx > mxx) mxx = vx;
            if (vy < mny) mny = vy;
            if (vy > mxy) mxy = vy;
        end
        return (ox > mnx) && (ox < mxx) && (oy > mny) && (oy < mxy);
    endfunction

    // Engine model: reads 7 points per slot, strobes geo_valid at wait_cnt 12.
    initial begin
        int slot_len;
        bit slot_sup, proto_now, proto_done, to_seen, to_check;
        logic [139:0] cap;
        logic [139:0] ef;
        slot_len = PTS_PER_FRAME + ENGINE_LAT;
        slot_sup = 0; proto_now = 0; proto_done = 0; to_seen = 0; to_check = 0;
        cap = '0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                phase = 0; geo_valid = 1'b0; to_seen = 0; to_check = 0;
                eng_real = 1'b0; proto_now = 0;
            end else begin
                if (phase == 0) begin
                    if (to_check) begin
                        check("err_timeout_after", err_timeout, 1);
                        to_check = 0;
                    end
                    slot_sup = suppress;
                    slot_len = slot_sup ? PTS_PER_FRAME + TIMEOUT : PTS_PER_FRAME + ENGINE_LAT;
                    eng_real = 1'b0;
                    proto_now = proto_arm && !proto_done && ((geo_x != 0) || (geo_y != 0));
                    if (proto_now) proto_done = 1;
                end
                if (phase < 7) cap[phase*20 +: 20] = {geo_x, geo_y};
                if (phase == 6) begin
                    eng_real = (cap != '0);
                    if (eng_real) begin
                        check("frame_queued", int'(exp_frame_q.size() != 0), 1);
                        if (exp_frame_q.size() != 0) begin
                            ef = exp_frame_q.pop_front();
                            check_vec("geo_frame", cap, ef);
                        end
                        geo_is_inside = bbox_inside(cap);
                    end else begin
                        geo_is_inside = 1'b0;
                    end
                end
                if (proto_now && phase == 3) check("err_proto_before", err_proto, 0);
                if (proto_now && phase == 4) check("err_proto_after", err_proto, 1);
                if (slot_sup && phase == slot_len - 1) begin
                    check("err_timeout_before", err_timeout, int'(to_seen));
                    to_seen = 1;
                    to_check = 1;
                end
                geo_valid = (!slot_sup && phase == slot_len - 1) || (proto_now && phase == 3);
                phase++;
                if (phase == slot_len) phase = 0;
            end
        end
    end

    // Result monitor: compares each consumed result with the scoreboard head.
    initial begin
        logic [1:0] er;
        forever begin
            @(negedge clk); #2;
            if (!reset && res_valid && res_ready) begin
                check("res_queued", int'(exp_res_q.size() != 0), 1);
                if (exp_res_q.size() != 0) begin
                    er = exp_res_q.pop_front();
                    check("res_inside", res_inside, er[1]);
                    check("res_timeout", res_timeout, er[0]);
                end
            end
        end
    end

    task automatic load_frame(input int ox, input int oy, input int s,
                              input logic [1:0] er, input bit want_res);
        logic [139:0] f;
        int budget;
        bit acc;
        f = make_frame(ox, oy, s);
        for (int i = 0; i < 7; i++) begin
            budget = 0;
            acc = 0;
            while (!acc) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_x = f[i*20+10 +: 10];
                in_y = f[i*20 +: 10];
                #1;
                acc = in_ready;
                budget++;
                if (!acc && budget > 400) begin
                    check("load_accept", int'(acc), 1);
                    return;
                end
            end
        end
        exp_frame_q.push_back(f);
        if (want_res) exp_res_q.push_back(er);
    endtask

    task automatic idle_input();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_res_q.size() != 0 || exp_frame_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_res_q.size() + exp_frame_q.size(), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_geo_x", geo_x, 0);
        check("rst_geo_y", geo_y, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_inside", res_inside, 0);
        check("rst_res_timeout", res_timeout, 0);
        check("rst_err_proto", err_proto, 0);
        check("rst_err_timeout", err_timeout, 0);
        @(negedge clk);
        reset = 1'b0;

        repeat (45) @(negedge clk);
        #3;
        check("idle_res_valid", res_valid, 0);
        check("idle_err_timeout", err_timeout, 0);
        check("idle_err_proto", err_proto, 0);

        load_frame(5, 5, 10, 2'b10, 1);
        idle_input();
        wait_drain(100);

        load_frame(20, 20, 10, 2'b00, 1);
        load_frame(3, 7, 10, 2'b10, 1);
        load_frame(100, 50, 100, 2'b00, 1);
        idle_input();
        wait_drain(300);

        res_ready = 1'b0;
        load_frame(1, 1, 4, 2'b10, 1);
        load_frame(4, 2, 4, 2'b00, 1);
        load_frame(2, 3, 4, 2'b10, 1);
        load_frame(7, 7, 8, 2'b10, 1);
        idle_input();
        repeat (60) @(negedge clk);
        #3;
        check("stall_in_ready", in_ready, 0);
        check("stall_res_valid", res_valid, 1);
        check("stall_head_inside", res_inside, 1);
        @(negedge clk);
        res_ready = 1'b1;
        wait_drain(300);

        suppress = 1'b1;
        load_frame(5, 5, 10, 2'b01, 1);
        idle_input();
        wait_drain(400);
        suppress = 1'b0;
        check("err_timeout_sticky", err_timeout, 1);

        proto_arm = 1'b1;
        load_frame(5, 6, 10, 2'b10, 1);
        idle_input();
        wait_drain(300);
        check("err_proto_sticky", err_proto, 1);

        load_frame(6, 6, 10, 2'b00, 0);
        idle_input();
        n = 0;
        while (!(eng_real && phase == 10) && n < 300) begin
            @(negedge clk); #3;
            n++;
        end
        check("reached_wait", int'(eng_real && phase == 10), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("mid_rst_err_proto", err_proto, 0);
        check("mid_rst_err_timeout", err_timeout, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_geo_x", geo_x, 0);
        @(negedge clk);
        reset = 1'b0;
        load_frame(2, 2, 10, 2'b10, 1);
        idle_input();
        wait_drain(200);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Transmit-side companion to the geofence engine: buffers 7-point frames (point 0 = test object, points 1..6 = fence vertices) from an upstream valid/ready stream.
- Serialises each frame onto the engine's X/Y bus one point per cycle.
- Waits for the engine's one-cycle valid, then returns is_inside as a result on a valid/ready stream.
- Keeps the engine's free-running 7-cycle read window fed; when no frame is ready it fills the slot with a discarded dummy frame.

Parameters:
- TIMEOUT, 32, maximum WAIT cycles for geo_valid before the frame is abandoned (must be >= 14).
- RES_DEPTH, 2, result FIFO depth (credits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream point valid
- in_ready  out  1  upstream point accepted when in_valid & in_ready
- in_x  in  10  point X (unsigned)
- in_y  in  10  point Y (unsigned)
- geo_x  out  10  X to engine
- geo_y  out  10  Y to engine
- geo_valid  in  1  engine result strobe
- geo_is_inside  in  1  engine result
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_inside  out  1  is_inside of the frame
- res_timeout  out  1  frame abandoned on timeout (res_inside = 0)
- err_proto  out  1  sticky: geo_valid seen during SEND
- err_timeout  out  1  sticky: any timeout

Behaviour:
Clock and reset:
- One clock (clk). reset is synchronous and active-high; it is the same reset line that drives the engine.
Reset values:
- in_ready = 1.
- geo_x = 0, geo_y = 0.
- res_valid = 0, res_inside = 0, res_timeout = 0.
- err_proto = 0, err_timeout = 0.
- Both banks empty, FIFO empty, state SEND with pt_cnt = 0.
Load side:
- Two 7x(10+10) point banks (ping-pong).
- Beats are written to the fill bank at index ld_cnt (0..6).
- On the 7th beat the bank is marked full, the fill pointer toggles and ld_cnt = 0.
- in_ready = fill bank not full.
FSM:
- SEND (pt_cnt 0..6):
  - On entry (pt_cnt = 0) the frame is latched as real if the send bank is full and (fifo_count + inflight) < RES_DEPTH; otherwise it is dummy.
  - geo_x/geo_y combinationally present point pt_cnt of the send bank, or 0 for a dummy frame.
  - The first cycle after reset deasserts is SEND pt_cnt = 0.
  - After pt_cnt = 6: go to WAIT and release the bank (mark it empty, toggle the send pointer) if the frame was real.
- WAIT:
  - wait_cnt increments from 0.
  - On geo_valid: push {geo_is_inside, 0} if real; next cycle is SEND pt_cnt = 0.
  - If wait_cnt = TIMEOUT-1 without geo_valid: push {0, 1} if real, set err_timeout, go to SEND.
  - Nominal geo_valid arrives at wait_cnt = 12, giving a 20-cycle frame period.
  - geo_x/geo_y hold 0 in WAIT.
- geo_valid during SEND: ignored, err_proto set.
Result FIFO:
- res_valid = not empty; the head is popped on res_valid & res_ready.
- The credit check guarantees a push never finds the FIFO full.
- Simultaneous push and pop is allowed.
Simultaneous events:
- A load completing and a release on different banks happen independently.
- A load into a bank being released in the same cycle is impossible, because in_ready is low while that bank is full.
Reset mid-operation:
- Partial loads, in-flight frames and FIFO contents are discarded; the sticky errors clear.

Optional Feature:
- GEOF_FRAME_ID_EN defined:
  - 8-bit in_id input, sampled on the first beat of each frame and stored per bank.
  - 8-bit res_id output, returned alongside res_inside for real frames.
  - Dummy frames consume no id.
- Undefined: no id ports, no storage.

Decomposition:
- Package geofence_pkg holds:
  - PT_W = 10.
  - PTS_PER_FRAME = 7.
  - ENGINE_LAT = 13 (nominal WAIT cycles to valid).
  - Point struct {x, y}.
  - FSM state enum {SEND, WAIT}.
- One sub-module: geofence_res_fifo (parameterised depth, width 2 or 10 with the id).
- The bank and FSM logic stay in the top.

Test Plan:
- Reset then idle, no input: dummy frames send geo_x/geo_y = 0 for 7 cycles; geo_valid at wait_cnt 12 gives no res_valid; the frame period is 20 cycles.
- Load object (5,5) with square vertices (0,0),(10,0),(10,10),(0,10),(0,5),(5,0); engine returns 1 -> res_valid with res_inside = 1, res_timeout = 0; geo_x shows 5,0,10,10,0,0,5 on consecutive SEND cycles.
- Back-to-back: three frames streamed continuously with res_ready = 1 -> three results in order; in_ready drops only while both banks are full.
- res_ready held 0: after 2 results are pending, the next slots send dummy frames; in_ready stays 0 once both banks are full; results resume in order on release.
- geo_valid suppressed: at wait_cnt 31 -> res_timeout = 1, err_timeout = 1, next SEND starts the following cycle.
- geo_valid pulsed during SEND pt_cnt 3 -> err_proto = 1, no FIFO push; reset mid-WAIT clears everything and restarts at SEND pt_cnt 0.
